// File: rtl/board_checker_if.sv
// Handshake and board-map bundle between the game-state FSM and the line checker.
interface board_checker_if #(
  parameter int CELLS_NUMBER = 16
);
  logic                    start;
  logic [CELLS_NUMBER-1:0] in_gameboard;
  logic [CELLS_NUMBER-1:0] in_players_cells;
  logic                    busy;
  logic                    done;
  logic                    win_valid;
  logic                    winner;
  logic [3:0]              win_line;
  logic                    draw;

  modport master (
    output start, in_gameboard, in_players_cells,
    input  busy, done, win_valid, winner, win_line, draw
  );

  modport slave (
    input  start, in_gameboard, in_players_cells,
    output busy, done, win_valid, winner, win_line, draw
  );
endinterface

// File: rtl/board_checker.sv
// Connect-4 (4x4) result checker: snapshots the board on start, then tests one
// of the ten four-in-a-line patterns per clock and reports win, line or draw.
module board_checker #(
  parameter int CELLS_NUMBER = 16
) (
  input  logic             clk,
  input  logic             reset,
  board_checker_if.slave   bus
);

  generate
    if (CELLS_NUMBER != 16) begin : g_bad_size
      $error("board_checker supports only CELLS_NUMBER = 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [3:0] LAST_LINE = 4'd9;
  localparam logic [3:0] NO_LINE   = 4'hF;

  // Cell masks: rows 0-3, columns 4-7, diagonal 8, anti-diagonal 9.
  function automatic logic [15:0] line_mask(input logic [3:0] idx);
    case (idx)
      4'd0:    line_mask = 16'h000F;
      4'd1:    line_mask = 16'h00F0;
      4'd2:    line_mask = 16'h0F00;
      4'd3:    line_mask = 16'hF000;
      4'd4:    line_mask = 16'h1111;
      4'd5:    line_mask = 16'h2222;
      4'd6:    line_mask = 16'h4444;
      4'd7:    line_mask = 16'h8888;
      4'd8:    line_mask = 16'h8421;
      4'd9:    line_mask = 16'h1248;
      default: line_mask = 16'h0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] gb_q, gb_d;
  logic [15:0] pc_q, pc_d;
  logic        win_valid_q, win_valid_d;
  logic        winner_q, winner_d;
  logic [3:0]  win_line_q, win_line_d;
  logic        draw_q, draw_d;

  logic [15:0] mask;
  logic [15:0] owners;
  logic        line_hit;

  // Owner bits are only compared under a full-occupancy mask, so stale owner
  // bits on empty cells can never complete a line.
  assign mask     = line_mask(cnt_q);
  assign owners   = pc_q & mask;
  assign line_hit = ((gb_q & mask) == mask) && ((owners == mask) || (owners == 16'h0000));

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gb_d        = gb_q;
    pc_d        = pc_q;
    win_valid_d = win_valid_q;
    winner_d    = winner_q;
    win_line_d  = win_line_q;
    draw_d      = draw_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          gb_d        = bus.in_gameboard;
          pc_d        = bus.in_players_cells;
          cnt_d       = 4'd0;
          win_valid_d = 1'b0;
          winner_d    = 1'b0;
          win_line_d  = NO_LINE;
          draw_d      = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (line_hit) begin
          win_valid_d = 1'b1;
          winner_d    = |owners;
          win_line_d  = cnt_q;
          state_d     = DONE;
        end else if (cnt_q == LAST_LINE) begin
          draw_d  = &gb_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous (sampled only at the clock edge) and all state,
  // including the snapshot, uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      gb_q        <= 16'h0000;
      pc_q        <= 16'h0000;
      win_valid_q <= 1'b0;
      winner_q    <= 1'b0;
      win_line_q  <= NO_LINE;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gb_q        <= gb_d;
      pc_q        <= pc_d;
      win_valid_q <= win_valid_d;
      winner_q    <= winner_d;
      win_line_q  <= win_line_d;
      draw_q      <= draw_d;
    end
  end

  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.win_valid = win_valid_q;
  assign bus.winner    = winner_q;
  assign bus.win_line  = win_line_q;
  assign bus.draw      = draw_q;

endmodule

// File: tb/tb_board_checker.sv
// Scoreboard bench for board_checker: expected results are queued at start and
// compared against the DUT outputs and latency when done pulses.
module tb_board_checker;

  typedef struct {
    logic       win_valid;
    logic       winner;
    logic [3:0] win_line;
    logic       draw;
    int         latency;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Cell indices of each line, written out independently of the DUT masks.
  int line_cells [10][4] = '{
    '{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 14, 15},
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{3, 6, 9, 12}
  };

  board_checker_if #(.CELLS_NUMBER(16)) bus ();

  board_checker #(.CELLS_NUMBER(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] gb, input logic [15:0] pc);
    exp_t e;
    bit   found = 1'b0;
    e.win_valid = 1'b0;
    e.winner    = 1'b0;
    e.win_line  = 4'hF;
    e.draw      = 1'b0;
    e.latency   = 11;
    for (int l = 0; l < 10; l++) begin
      bit occ = 1'b1;
      bit p1  = 1'b1;
      bit p2  = 1'b1;
      for (int k = 0; k < 4; k++) begin
        occ = occ & gb[line_cells[l][k]];
        p1  = p1 & !pc[line_cells[l][k]];
        p2  = p2 & pc[line_cells[l][k]];
      end
      if (!found && occ && (p1 || p2)) begin
        found       = 1'b1;
        e.win_valid = 1'b1;
        e.winner    = p2;
        e.win_line  = 4'(l);
        e.latency   = l + 2;
      end
    end
    e.draw = !found && (&gb);
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_win_valid"}, 32'(bus.win_valid), 32'd0);
    check({tag, "_winner"},    32'(bus.winner),    32'd0);
    check({tag, "_win_line"},  32'(bus.win_line),  32'hF);
    check({tag, "_draw"},      32'(bus.draw),      32'd0);
  endtask

  // Drives start for one edge from a falling edge; also releases reset.
  task automatic start_scan(input logic [15:0] gb, input logic [15:0] pc, input bit push);
    @(negedge clk);
    if (push) sb_q.push_back(model(gb, pc));
    reset                = 1'b1;
    bus.start            = 1'b1;
    bus.in_gameboard     = gb;
    bus.in_players_cells = pc;
  endtask

  // Counts falling edges after the start cycle until done, then scores the result.
  task automatic wait_result(input bit disturb);
    int   cyc  = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
      end
      if (disturb && cyc == 3) begin
        bus.start            = 1'b1;
        bus.in_gameboard     = 16'(~bus.in_gameboard);
        bus.in_players_cells = 16'($urandom);
      end
      if (disturb && cyc == 4) bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("latency",   32'(cyc),           32'(e.latency));
          check("win_valid", 32'(bus.win_valid), 32'(e.win_valid));
          check("winner",    32'(bus.winner),    32'(e.winner));
          check("win_line",  32'(bus.win_line),  32'(e.win_line));
          check("draw",      32'(bus.draw),      32'(e.draw));
          check("busy_at_done", 32'(bus.busy),   32'd0);
        end
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int extra;
    reset                = 1'b0;
    bus.start            = 1'b0;
    bus.in_gameboard     = 16'h0000;
    bus.in_players_cells = 16'h0000;

    // Reset held two cycles, start asserted in the release cycle.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    start_scan(16'h0000, 16'h0000, 1'b1);
    wait_result(1'b0);

    // Directed boards, back to back.
    start_scan(16'h000F, 16'h000F, 1'b1); wait_result(1'b0);
    start_scan(16'h2222, 16'h0000, 1'b1); wait_result(1'b0);
    start_scan(16'h0222, 16'h2000, 1'b1); wait_result(1'b0);
    start_scan(16'h1248, 16'h1248, 1'b1); wait_result(1'b0);
    start_scan(16'hFFFF, 16'hC3C3, 1'b1); wait_result(1'b0);
    start_scan(16'hFFFF, 16'h00FF, 1'b1); wait_result(1'b0);
    start_scan(16'h8421, 16'h0000, 1'b1); wait_result(1'b0);
    start_scan(16'h8888, 16'h8888, 1'b1); wait_result(1'b0);

    // Results hold after done.
    repeat (3) @(negedge clk);
    check("hold_win_line", 32'(bus.win_line), 32'd7);
    check("hold_winner",   32'(bus.winner),   32'd1);

    // Dense random boards.
    for (int i = 0; i < 16; i++) begin
      start_scan(16'($urandom | $urandom | $urandom), 16'($urandom), 1'b1);
      wait_result(1'b0);
    end

    // Second start and input changes mid-scan are ignored; one done only.
    start_scan(16'hFFFF, 16'hC3C3, 1'b1);
    wait_result(1'b1);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("single_done", 32'(extra), 32'd0);

    // Reset at scan cycle 4 aborts without a done pulse.
    start_scan(16'h0222, 16'h2000, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset_outputs("midscan_reset");
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("no_done_after_reset", 32'(extra), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
